// File: rtl/xorshift_arbiter.sv
// xorshift_arbiter
// Sequencer and round-robin arbiter sitting in front of one shared xorshift
// PRNG. After reset or a reseed it loads the seed into the PRNG, throws away
// a fixed number of warm-up words, and then hands out one fresh word per
// grant to the requesters in round-robin order.

module xorshift_arbiter #(
   parameter int                 N_REQ        = 4,
   parameter int                 WIDTH        = 32,
   parameter logic [WIDTH-1:0]   DEFAULT_SEED = 32'h92D68CA2,
   parameter int                 WARMUP       = 8
) (
   input  logic               clk,
   input  logic               arst,
   input  logic [N_REQ-1:0]   req,
   output logic [N_REQ-1:0]   ack,
   output logic [WIDTH-1:0]   data,
   input  logic               reseed,
   input  logic [WIDTH-1:0]   reseed_val,
   output logic               ready,
   output logic               prng_load,
   output logic               prng_en,
   output logic [WIDTH-1:0]   prng_seed,
   input  logic [WIDTH-1:0]   prng_random
);

   // Pointer width, plus one spare bit so the wrap-around sum cannot overflow
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int SW = PW + 1;

   // Last warm-up count value; only meaningful when WARMUP is non-zero
   localparam logic [7:0] WARM_LAST = (WARMUP > 0) ? 8'(WARMUP - 1) : 8'd0;

   typedef enum logic [1:0] {
      LOAD  = 2'd0,
      WARM  = 2'd1,
      SERVE = 2'd2
   } StateT;

   StateT              state;
   logic [PW-1:0]      rrPtr;
   logic [7:0]         warmCnt;

   logic [N_REQ-1:0]   eligible;
   logic               found;
   logic [PW-1:0]      winner;
   logic [SW-1:0]      searchSum;
   logic [PW-1:0]      searchIdx;
   logic               grant;
   logic [PW-1:0]      nextPtr;
   logic [N_REQ-1:0]   winnerOneHot;

   // A requester that was just acked sits out one cycle, which gives the
   // others a chance even if its request line stays high.
   assign eligible = req & ~ack;

   // Scan the requesters starting at the round-robin pointer and wrapping
   // around; the first eligible one wins. The sum keeps a spare bit so the
   // wrap also works when N_REQ is not a power of two.
   always_comb begin
      found     = 1'b0;
      winner    = '0;
      searchSum = '0;
      searchIdx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         searchSum = {1'b0, rrPtr} + SW'(i);
         if (searchSum >= SW'(N_REQ)) begin
            searchSum = searchSum - SW'(N_REQ);
         end
         searchIdx = searchSum[PW-1:0];
         if (!found && eligible[searchIdx]) begin
            found  = 1'b1;
            winner = searchIdx;
         end
      end
   end

   // A grant happens only while serving, and a reseed in the same cycle
   // wins over arbitration so that no word leaves with a stale seed.
   assign grant        = (state == SERVE) && !reseed && found;
   assign nextPtr      = (winner == PW'(N_REQ - 1)) ? '0 : winner + PW'(1);
   assign winnerOneHot = {{(N_REQ-1){1'b0}}, 1'b1} << winner;

   // The PRNG control lines come straight from the state. Each grant steps
   // the PRNG once, so the word latched this cycle is never reused.
   assign prng_load = (state == LOAD);
   assign prng_en   = (state == WARM) || grant;
   assign ready     = (state == SERVE);

   // Sequencing and grant registers. ack is a one-cycle pulse, so it
   // defaults to zero every cycle and is set only on a grant. The pointer
   // survives a reseed so fairness carries over into the next seed epoch.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state     <= LOAD;
         ack       <= '0;
         data      <= '0;
         prng_seed <= DEFAULT_SEED;
         rrPtr     <= '0;
         warmCnt   <= '0;
      end else begin
         ack <= '0;
         if (reseed) begin
            prng_seed <= (reseed_val == '0) ? DEFAULT_SEED : reseed_val;
            state     <= LOAD;
            warmCnt   <= '0;
         end else begin
            case (state)
               LOAD: begin
                  warmCnt <= '0;
                  state   <= (WARMUP > 0) ? WARM : SERVE;
               end
               WARM: begin
                  if (warmCnt == WARM_LAST) begin
                     warmCnt <= '0;
                     state   <= SERVE;
                  end else begin
                     warmCnt <= warmCnt + 8'd1;
                  end
               end
               SERVE: begin
                  if (found) begin
                     ack   <= winnerOneHot;
                     data  <= prng_random;
                     rrPtr <= nextPtr;
                  end
               end
               default: begin
                  state <= LOAD;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_xorshift_arbiter.sv
// tb_xorshift_arbiter
// Drives the arbiter with directed scenarios followed by random traffic. A
// simple xorshift32 PRNG stub sits on the PRNG ports. The reference model
// predicts every output each cycle from the seed-epoch/grant-count view:
// the n-th word handed out after a seed load is xorshift applied
// (WARMUP + n) times to that seed.

module tb_xorshift_arbiter;

   localparam int          N   = 4;
   localparam int          W   = 32;
   localparam int          WU  = 8;
   localparam logic [31:0] DEF = 32'h92D68CA2;

   logic          clock = 1'b0;
   logic          arst;
   logic [N-1:0]  req;
   logic [N-1:0]  ack;
   logic [W-1:0]  data;
   logic          reseed;
   logic [W-1:0]  reseedVal;
   logic          ready;
   logic          prngLoad;
   logic          prngEn;
   logic [W-1:0]  prngSeed;
   logic [W-1:0]  prngRandom;
   logic [W-1:0]  prngState;

   int checks = 0;
   int errors = 0;
   int loadSeen = 0;
   int enSeen = 0;

   // Reference model state
   bit            mLoad;
   int            mWarmLeft;
   int            mPtr;
   int            mLastAck;
   int            mGrants;
   int            mWin;
   logic [31:0]   mSeed;
   logic [31:0]   mData;

   xorshift_arbiter #(
      .N_REQ(N), .WIDTH(W), .DEFAULT_SEED(DEF), .WARMUP(WU)
   ) dut (
      .clk(clock), .arst(arst), .req(req), .ack(ack), .data(data),
      .reseed(reseed), .reseed_val(reseedVal), .ready(ready),
      .prng_load(prngLoad), .prng_en(prngEn), .prng_seed(prngSeed),
      .prng_random(prngRandom)
   );

   // Free-running clock, 10 time units per period
   always #5 clock = ~clock;

   function automatic logic [31:0] xs(input logic [31:0] x);
      logic [31:0] y;
      y = x;
      y = y ^ (y << 13);
      y = y ^ (y >> 17);
      y = y ^ (y << 5);
      return y;
   endfunction

   function automatic logic [31:0] xsN(input logic [31:0] seed, input int n);
      logic [31:0] y;
      y = seed;
      for (int k = 0; k < n; k++) y = xs(y);
      return y;
   endfunction

   // PRNG stub: registered state, load has priority over step
   always @(posedge clock) begin
      if (prngLoad) prngState <= prngSeed;
      else if (prngEn) prngState <= xs(prngState);
   end
   assign prngRandom = prngState;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic resetModel();
      mLoad     = 1'b1;
      mWarmLeft = 0;
      mPtr      = 0;
      mLastAck  = -1;
      mGrants   = 0;
      mSeed     = DEF;
      mData     = '0;
   endtask

   // Compare every DUT output against the model for the current cycle
   task automatic checkOutput();
      logic        serving;
      logic [3:0]  expAck;
      logic        expEn;
      int          idx;
      serving = !mLoad && (mWarmLeft == 0);
      expAck  = (mLastAck >= 0) ? 4'(1 << mLastAck) : 4'd0;
      mWin    = -1;
      if (serving && !reseed && !arst) begin
         for (int off = 0; off < N; off++) begin
            idx = (mPtr + off) % N;
            if (mWin < 0 && req[idx] && idx != mLastAck) mWin = idx;
         end
      end
      expEn = (!mLoad && mWarmLeft > 0) || (mWin >= 0);
      if (prngLoad) loadSeen++;
      if (prngEn) enSeen++;
      check("ack",       32'(ack),      32'(expAck));
      check("data",      data,          mData);
      check("ready",     32'(ready),    32'(serving));
      check("prng_load", 32'(prngLoad), 32'(mLoad));
      check("prng_en",   32'(prngEn),   32'(expEn));
      check("prng_seed", prngSeed,      mSeed);
   endtask

   // Advance the model across one clock edge using this cycle's inputs
   task automatic stepModel();
      if (reseed) begin
         mSeed     = (reseedVal == 0) ? DEF : reseedVal;
         mLoad     = 1'b1;
         mWarmLeft = 0;
         mLastAck  = -1;
      end else if (mLoad) begin
         mLoad     = 1'b0;
         mWarmLeft = WU;
         mGrants   = 0;
         mLastAck  = -1;
      end else if (mWarmLeft > 0) begin
         mWarmLeft--;
         mLastAck = -1;
      end else if (mWin >= 0) begin
         mData    = xsN(mSeed, WU + mGrants);
         mGrants++;
         mLastAck = mWin;
         mPtr     = (mWin + 1) % N;
      end else begin
         mLastAck = -1;
      end
   endtask

   // Entered and left one time unit after a rising edge
   task automatic applyStimulus(input logic [3:0] r, input logic rs, input logic [31:0] rv);
      req       = r;
      reseed    = rs;
      reseedVal = rv;
      #1;
      checkOutput();
      stepModel();
      @(posedge clock);
      #1;
   endtask

   // Raise arst between edges, confirm the outputs clear before the next
   // edge, hold it two edges and release one time unit after an edge
   task automatic asyncReset();
      #2;
      arst   = 1'b1;
      req    = '0;
      reseed = 1'b0;
      #1;
      resetModel();
      checkOutput();
      @(posedge clock);
      #1;
      checkOutput();
      @(posedge clock);
      #1;
      arst = 1'b0;
   endtask

   initial begin
      bit seen;
      logic [3:0]  r;
      logic        rs;
      logic [31:0] rv;

      arst      = 1'b1;
      req       = '0;
      reseed    = 1'b0;
      reseedVal = '0;
      resetModel();
      $display("[TB] reset");
      @(posedge clock);
      #2;
      checkOutput();
      @(posedge clock);
      #1;
      arst = 1'b0;

      // T1: load pulse, eight warm steps, then ready
      $display("[TB] T1 reset sequence");
      loadSeen = 0;
      enSeen   = 0;
      repeat (12) applyStimulus(4'b0000, 1'b0, '0);
      check("t1_load_cycles", 32'(loadSeen), 32'd1);
      check("t1_en_cycles",   32'(enSeen),   32'd8);
      check("t1_ready",       32'(ready),    32'd1);

      // T2: single requester, ack every second cycle
      $display("[TB] T2 single requester");
      repeat (12) applyStimulus(4'b0001, 1'b0, '0);

      // T3: all requesting, round-robin order
      $display("[TB] T3 round robin");
      repeat (12) applyStimulus(4'b1111, 1'b0, '0);

      // T4: grant to bit 3, then the pointer wraps to bit 0
      $display("[TB] T4 wrap");
      seen = 1'b0;
      for (int k = 0; k < 8; k++) begin
         applyStimulus(4'b1000, 1'b0, '0);
         if (ack == 4'b1000) begin
            seen = 1'b1;
            break;
         end
      end
      check("t4_grant3_seen", 32'(seen), 32'd1);
      applyStimulus(4'b1001, 1'b0, '0);
      check("t4_wrap_ack0", 32'(ack), 32'b0001);
      applyStimulus(4'b1001, 1'b0, '0);
      check("t4_then_ack3", 32'(ack), 32'b1000);

      // T5: reseed to a random value, then reseed with zero
      $display("[TB] T5 reseed");
      applyStimulus(4'b1111, 1'b1, $urandom | 32'h1);
      repeat (14) applyStimulus(4'b1111, 1'b0, '0);
      applyStimulus(4'b1111, 1'b1, 32'h0);
      check("t5_seed_default", prngSeed, 32'h92D68CA2);
      repeat (14) applyStimulus(4'b1111, 1'b0, '0);

      // T6: async reset during WARM and during SERVE
      $display("[TB] T6 async reset");
      applyStimulus(4'b0101, 1'b1, 32'h1234_5678);
      repeat (4) applyStimulus(4'b0101, 1'b0, '0);
      asyncReset();
      repeat (12) applyStimulus(4'b0000, 1'b0, '0);
      repeat (3) applyStimulus(4'b1111, 1'b0, '0);
      asyncReset();
      repeat (14) applyStimulus(4'b0110, 1'b0, '0);

      // Random traffic with occasional reseeds and resets
      $display("[TB] random traffic");
      for (int k = 0; k < 500; k++) begin
         r  = 4'($urandom_range(0, 15));
         rs = ($urandom_range(0, 29) == 0);
         rv = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
         if ($urandom_range(0, 149) == 0) asyncReset();
         applyStimulus(r, rs, rv);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
